// File: rtl/xaui_link_sequencer.sv
// -----------------------------------------------------------------------------
// xaui_link_sequencer
//
// Purpose:
//   Brings up and supervises N_CH independent XAUI receive channels of four
//   lanes each. Every enabled channel walks RESET -> WAIT_LOCK -> ALIGN ->
//   BOND -> UP. It drops back to RESET on a timeout, on a fault while UP, or
//   on a resync request. Channels whose ENABLE bit is clear stay in DISABLED
//   with every output held at 0.
//
// Ports:
//   xaui_clk           in   1          sole clock, rising edge
//   reset              in   1          synchronous, active-high reset
//   resync             in   N_CH       per-channel restart request
//   mgt_rxlock         in   4*N_CH     per-lane CDR lock (channel i: [4i+3:4i])
//   mgt_rxsyncok       in   4*N_CH     per-lane comma alignment achieved
//   mgt_rxbufferr      in   4*N_CH     per-lane elastic buffer error
//   mgt_rx_rst         out  N_CH       per-channel rx reset
//   mgt_rxencommaalign out  4*N_CH     per-lane comma-align enable
//   mgt_rxenchansync   out  N_CH       per-channel channel-bonding enable
//   link_up            out  N_CH       per-channel link operational
//   link_state         out  3*N_CH     per-channel state code
//   err_count          out  CNT_W*N_CH faults that dropped the link from UP
//   retry_count        out  CNT_W*N_CH WAIT_LOCK / ALIGN timeouts
// -----------------------------------------------------------------------------
module xaui_link_sequencer #(
  parameter int unsigned       N_CH         = 8,
  parameter logic [N_CH-1:0]   ENABLE       = 8'h30,
  parameter int unsigned       RST_CYCLES   = 16,
  parameter int unsigned       LOCK_TIMEOUT = 1024,
  parameter int unsigned       SYNC_TIMEOUT = 4096,
  parameter int unsigned       BOND_CYCLES  = 64,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic                  xaui_clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       resync,
  input  logic [4*N_CH-1:0]     mgt_rxlock,
  input  logic [4*N_CH-1:0]     mgt_rxsyncok,
  input  logic [4*N_CH-1:0]     mgt_rxbufferr,
  output logic [N_CH-1:0]       mgt_rx_rst,
  output logic [4*N_CH-1:0]     mgt_rxencommaalign,
  output logic [N_CH-1:0]       mgt_rxenchansync,
  output logic [N_CH-1:0]       link_up,
  output logic [3*N_CH-1:0]     link_state,
  output logic [CNT_W*N_CH-1:0] err_count,
  output logic [CNT_W*N_CH-1:0] retry_count
);

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_BOND      = 3'd4,
    ST_UP        = 3'd5
  } state_e;

  // One shared timer per channel must hold the longest phase duration.
  localparam int unsigned T_MAX_A = (RST_CYCLES > BOND_CYCLES) ? RST_CYCLES : BOND_CYCLES;
  localparam int unsigned T_MAX_B = (LOCK_TIMEOUT > SYNC_TIMEOUT) ? LOCK_TIMEOUT : SYNC_TIMEOUT;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

  // Timer value seen in the last cycle of each phase.
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SYNC_LAST = TMR_W'(SYNC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BOND_LAST = TMR_W'(BOND_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam bit CH_EN = ENABLE[ch];

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic             rx_rst_q, rx_rst_d;
    logic             align_q, align_d;
    logic             chansync_q, chansync_d;
    logic             up_q, up_d;
    logic             lock_all, sync_all, buf_any, lane_ok;

    // Next-state logic. Every transition clears the timer, and so does a
    // resync that re-enters RESET from RESET. In UP a fault takes priority over
    // resync so that a coincident pair still counts as one error.
    always_comb begin
      lock_all = &mgt_rxlock[4*ch +: 4];
      sync_all = &mgt_rxsyncok[4*ch +: 4];
      buf_any  = |mgt_rxbufferr[4*ch +: 4];
      lane_ok  = lock_all & sync_all & ~buf_any;

      state_d = state_q;
      timer_d = timer_q;
      err_d   = err_q;
      retry_d = retry_q;

      if (!CH_EN) begin
        state_d = ST_DISABLED;
        timer_d = '0;
        err_d   = '0;
        retry_d = '0;
      end else begin
        case (state_q)
          ST_RESET: begin
            if (resync[ch]) begin
              timer_d = '0;
            end else if (timer_q == RST_LAST) begin
              state_d = ST_WAIT_LOCK;
              timer_d = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (resync[ch]) begin
              state_d = ST_RESET;
              timer_d = '0;
            end else if (lock_all) begin
              state_d = ST_ALIGN;
              timer_d = '0;
            end else if (timer_q == LOCK_LAST) begin
              state_d = ST_RESET;
              timer_d = '0;
              retry_d = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          ST_ALIGN: begin
            if (resync[ch]) begin
              state_d = ST_RESET;
              timer_d = '0;
            end else if (sync_all) begin
              state_d = ST_BOND;
              timer_d = '0;
            end else if (timer_q == SYNC_LAST) begin
              state_d = ST_RESET;
              timer_d = '0;
              retry_d = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          ST_BOND: begin
            // The timer counts consecutive clean cycles; any dirty cycle
            // starts the count again.
            if (resync[ch]) begin
              state_d = ST_RESET;
              timer_d = '0;
            end else if (!lane_ok) begin
              timer_d = '0;
            end else if (timer_q == BOND_LAST) begin
              state_d = ST_UP;
              timer_d = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          ST_UP: begin
            if (!lane_ok) begin
              state_d = ST_RESET;
              timer_d = '0;
              err_d   = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;
            end else if (resync[ch]) begin
              state_d = ST_RESET;
              timer_d = '0;
            end
          end
          default: begin
            // DISABLED or an unused code on an enabled channel: restart.
            state_d = ST_RESET;
            timer_d = '0;
          end
        endcase
      end

      rx_rst_d   = (state_d == ST_RESET);
      align_d    = (state_d == ST_ALIGN);
      chansync_d = (state_d == ST_BOND) || (state_d == ST_UP);
      up_d       = (state_d == ST_UP);
    end

    // State, timer, counters and output flops. Output flops are loaded from
    // the decode of the next state so they line up with state_q.
    always_ff @(posedge xaui_clk) begin
      if (reset) begin
        state_q    <= CH_EN ? ST_RESET : ST_DISABLED;
        timer_q    <= '0;
        err_q      <= '0;
        retry_q    <= '0;
        rx_rst_q   <= CH_EN;
        align_q    <= 1'b0;
        chansync_q <= 1'b0;
        up_q       <= 1'b0;
      end else begin
        state_q    <= state_d;
        timer_q    <= timer_d;
        err_q      <= err_d;
        retry_q    <= retry_d;
        rx_rst_q   <= rx_rst_d;
        align_q    <= align_d;
        chansync_q <= chansync_d;
        up_q       <= up_d;
      end
    end

    assign mgt_rx_rst[ch]                  = rx_rst_q;
    assign mgt_rxencommaalign[4*ch +: 4]   = {4{align_q}};
    assign mgt_rxenchansync[ch]            = chansync_q;
    assign link_up[ch]                     = up_q;
    assign link_state[3*ch +: 3]           = state_q;
    assign err_count[CNT_W*ch +: CNT_W]    = err_q;
    assign retry_count[CNT_W*ch +: CNT_W]  = retry_q;
  end

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xaui_link_sequencer
//
// Purpose:
//   Self-checking bench for xaui_link_sequencer. A per-channel phase/elapsed
//   model runs on every clock and a compare process checks all outputs on
//   each falling edge. Directed sequences add hand-computed expectations for
//   bring-up latency, faults, bond glitches, resync, timeouts, saturation and
//   mid-operation reset. Inputs of disabled channels are randomised on every
//   cycle, and the design must ignore them.
// -----------------------------------------------------------------------------
module tb_xaui_link_sequencer;

  localparam int          N_CH      = 8;
  localparam logic [7:0]  EN        = 8'h30;
  localparam logic [31:0] EN_LANES  = 32'h00FF_0000;
  localparam int          RST_C     = 16;
  localparam int          LOCK_TO   = 1024;
  localparam int          SYNC_TO   = 200;
  localparam int          BOND_C    = 64;
  localparam int          CNT_W     = 4;
  localparam int          SAT       = 15;

  localparam int S_DIS = 0, S_RST = 1, S_WL = 2, S_AL = 3, S_BD = 4, S_UP = 5;

  logic                  xaui_clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       resync;
  logic [4*N_CH-1:0]     mgt_rxlock, mgt_rxsyncok, mgt_rxbufferr;
  logic [N_CH-1:0]       mgt_rx_rst, mgt_rxenchansync, link_up;
  logic [4*N_CH-1:0]     mgt_rxencommaalign;
  logic [3*N_CH-1:0]     link_state;
  logic [CNT_W*N_CH-1:0] err_count, retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  xaui_link_sequencer #(
    .N_CH(N_CH), .ENABLE(EN), .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_TO),
    .SYNC_TIMEOUT(SYNC_TO), .BOND_CYCLES(BOND_C), .CNT_W(CNT_W)
  ) dut (
    .xaui_clk(xaui_clk), .reset(reset), .resync(resync),
    .mgt_rxlock(mgt_rxlock), .mgt_rxsyncok(mgt_rxsyncok), .mgt_rxbufferr(mgt_rxbufferr),
    .mgt_rx_rst(mgt_rx_rst), .mgt_rxencommaalign(mgt_rxencommaalign),
    .mgt_rxenchansync(mgt_rxenchansync), .link_up(link_up), .link_state(link_state),
    .err_count(err_count), .retry_count(retry_count)
  );

  always #5 xaui_clk = ~xaui_clk;

  // Reference model: each channel is a phase plus the number of cycles spent
  // in it (for BOND, the number of consecutive clean cycles).
  int m_st[N_CH], m_t[N_CH], m_err[N_CH], m_retry[N_CH];
  bit model_valid = 1'b0;

  always @(posedge xaui_clk) begin
    if (reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        m_st[ch] = EN[ch] ? S_RST : S_DIS;
        m_t[ch] = 0; m_err[ch] = 0; m_retry[ch] = 0;
      end
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (EN[ch]) begin
          bit lk, sy, bf, healthy, rs;
          int nst, nt;
          lk = (mgt_rxlock[4*ch +: 4] == 4'hF);
          sy = (mgt_rxsyncok[4*ch +: 4] == 4'hF);
          bf = (mgt_rxbufferr[4*ch +: 4] != 4'h0);
          healthy = lk && sy && !bf;
          rs = resync[ch];
          nst = m_st[ch];
          nt = m_t[ch] + 1;
          if (m_st[ch] == S_UP && !healthy) begin
            nst = S_RST;
            if (m_err[ch] < SAT) m_err[ch]++;
          end else if (rs) nst = S_RST;
          else if (m_st[ch] == S_RST && nt == RST_C) nst = S_WL;
          else if (m_st[ch] == S_WL && lk) nst = S_AL;
          else if (m_st[ch] == S_WL && nt == LOCK_TO) begin
            nst = S_RST;
            if (m_retry[ch] < SAT) m_retry[ch]++;
          end
          else if (m_st[ch] == S_AL && sy) nst = S_BD;
          else if (m_st[ch] == S_AL && nt == SYNC_TO) begin
            nst = S_RST;
            if (m_retry[ch] < SAT) m_retry[ch]++;
          end
          else if (m_st[ch] == S_BD && !healthy) nt = 0;
          else if (m_st[ch] == S_BD && nt == BOND_C) nst = S_UP;
          if (nst != m_st[ch] || rs) nt = 0;
          m_st[ch] = nst;
          m_t[ch] = nt;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]  e_rst, e_cs, e_up;
  logic [31:0] e_al, e_err, e_retry;
  logic [23:0] e_st;

  always @(negedge xaui_clk) begin
    if (model_valid) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        e_rst[ch] = (m_st[ch] == S_RST);
        e_cs[ch]  = (m_st[ch] == S_BD) || (m_st[ch] == S_UP);
        e_up[ch]  = (m_st[ch] == S_UP);
        e_al[4*ch +: 4]        = (m_st[ch] == S_AL) ? 4'hF : 4'h0;
        e_st[3*ch +: 3]        = 3'(m_st[ch]);
        e_err[CNT_W*ch +: CNT_W]   = CNT_W'(m_err[ch]);
        e_retry[CNT_W*ch +: CNT_W] = CNT_W'(m_retry[ch]);
      end
      checkOutput("model rx_rst", 64'(mgt_rx_rst), 64'(e_rst));
      checkOutput("model commaalign", 64'(mgt_rxencommaalign), 64'(e_al));
      checkOutput("model chansync", 64'(mgt_rxenchansync), 64'(e_cs));
      checkOutput("model link_up", 64'(link_up), 64'(e_up));
      checkOutput("model link_state", 64'(link_state), 64'(e_st));
      checkOutput("model err_count", 64'(err_count), 64'(e_err));
      checkOutput("model retry_count", 64'(retry_count), 64'(e_retry));
    end
  end

  // One cycle step: move 2 time units past the rising edge, then scramble the
  // inputs of disabled channels.
  task automatic tick();
    @(posedge xaui_clk);
    #2;
    mgt_rxlock    = (mgt_rxlock & EN_LANES)    | ($urandom() & ~EN_LANES);
    mgt_rxsyncok  = (mgt_rxsyncok & EN_LANES)  | ($urandom() & ~EN_LANES);
    mgt_rxbufferr = (mgt_rxbufferr & EN_LANES) | ($urandom() & ~EN_LANES);
    resync        = (resync & EN) | (8'($urandom()) & ~EN);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input int ch, input logic [3:0] lk, input logic [3:0] sy,
                               input logic [3:0] bf, input logic rs);
    mgt_rxlock[4*ch +: 4]    = lk;
    mgt_rxsyncok[4*ch +: 4]  = sy;
    mgt_rxbufferr[4*ch +: 4] = bf;
    resync[ch]               = rs;
  endtask

  function automatic int st_of(input int ch);
    return int'(link_state[3*ch +: 3]);
  endfunction
  function automatic int err_of(input int ch);
    return int'(err_count[CNT_W*ch +: CNT_W]);
  endfunction
  function automatic int retry_of(input int ch);
    return int'(retry_count[CNT_W*ch +: CNT_W]);
  endfunction

  // Counts ticks until link_up[ch] rises, giving up after 'limit' ticks.
  task automatic wait_up(input int ch, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (link_up[ch]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat_up, lat_rst;
    reset = 1'b1;
    resync = '0;
    mgt_rxlock = '0;
    mgt_rxsyncok = '0;
    mgt_rxbufferr = '0;
    applyStimulus(4, 4'hF, 4'hF, 4'h0, 1'b0);
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
    ticks(3);
    checkOutput("reset rx_rst", 64'(mgt_rx_rst), 64'h30);
    checkOutput("reset link_up", 64'(link_up), 64'h0);
    checkOutput("reset link_state", 64'(link_state), 64'h9000);
    checkOutput("reset commaalign", 64'(mgt_rxencommaalign), 64'h0);
    checkOutput("reset counters", {err_count, retry_count}, 64'h0);

    // Nominal bring-up.
    reset = 1'b0;
    lat_up = -1;
    lat_rst = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (lat_rst < 0 && !mgt_rx_rst[4]) lat_rst = k;
      if (link_up[4]) begin
        lat_up = k;
        break;
      end
    end
    checkOutput("rx_rst length", 64'(lat_rst), 64'd16);
    checkOutput("bring-up latency", 64'(lat_up), 64'd82);
    checkOutput("both links up", 64'(link_up), 64'h30);

    // Single-cycle buffer error on ch5 lane 2 while UP.
    applyStimulus(5, 4'hF, 4'hF, 4'b0100, 1'b0);
    tick();
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
    checkOutput("fault link_up", 64'(link_up), 64'h10);
    checkOutput("fault err5", 64'(err_of(5)), 64'd1);
    checkOutput("fault state5", 64'(st_of(5)), 64'd1);
    wait_up(5, 200, lat_up);
    checkOutput("fault re-bring-up", 64'(lat_up), 64'd82);

    // Resync alone in UP, then a sync glitch at BOND count 60.
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b1);
    tick();
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
    checkOutput("resync state5", 64'(st_of(5)), 64'd1);
    checkOutput("resync err5", 64'(err_of(5)), 64'd1);
    checkOutput("resync retry5", 64'(retry_of(5)), 64'd0);
    ticks(78);
    checkOutput("glitch pre state5", 64'(st_of(5)), 64'd4);
    applyStimulus(5, 4'hF, 4'b1110, 4'h0, 1'b0);
    tick();
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
    ticks(63);
    checkOutput("glitch not early", 64'(link_up[5]), 64'd0);
    tick();
    checkOutput("glitch up on time", 64'(link_up[5]), 64'd1);

    // Resync and fault in the same UP cycle.
    applyStimulus(5, 4'hF, 4'hF, 4'b0010, 1'b1);
    tick();
    applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
    checkOutput("resync+fault err5", 64'(err_of(5)), 64'd2);
    checkOutput("resync+fault state5", 64'(st_of(5)), 64'd1);
    ticks(82);
    checkOutput("resync+fault up", 64'(link_up[5]), 64'd1);

    // ch4: resync with sync low (also a fault), ALIGN timeout, reset mid-ALIGN.
    applyStimulus(4, 4'hF, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4, 4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("ch4 fault err4", 64'(err_of(4)), 64'd1);
    ticks(17);
    checkOutput("align state4", 64'(st_of(4)), 64'd3);
    checkOutput("align commaalign4", 64'(mgt_rxencommaalign[19:16]), 64'hF);
    ticks(199);
    checkOutput("align pre-timeout retry4", 64'(retry_of(4)), 64'd0);
    tick();
    checkOutput("align timeout state4", 64'(st_of(4)), 64'd1);
    checkOutput("align timeout retry4", 64'(retry_of(4)), 64'd1);
    ticks(23);
    checkOutput("align again state4", 64'(st_of(4)), 64'd3);
    reset = 1'b1;
    tick();
    checkOutput("midreset state4", 64'(st_of(4)), 64'd1);
    checkOutput("midreset counters", {err_count, retry_count}, 64'h0);
    checkOutput("midreset commaalign", 64'(mgt_rxencommaalign), 64'h0);
    checkOutput("midreset rx_rst", 64'(mgt_rx_rst), 64'h30);
    checkOutput("midreset link_up", 64'(link_up), 64'h0);
    reset = 1'b0;
    applyStimulus(4, 4'hF, 4'hF, 4'h0, 1'b0);
    ticks(82);
    checkOutput("post-reset up", 64'(link_up), 64'h30);

    // err_count saturation on ch5.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(5, 4'hF, 4'hF, 4'h1, 1'b0);
      tick();
      applyStimulus(5, 4'hF, 4'hF, 4'h0, 1'b0);
      ticks(82);
    end
    checkOutput("err5 saturated", 64'(err_of(5)), 64'd15);
    checkOutput("err5 sat link_up", 64'(link_up[5]), 64'd1);

    // Lock held low on ch4: fault, then repeated WAIT_LOCK timeouts.
    applyStimulus(4, 4'h0, 4'hF, 4'h0, 1'b0);
    tick();
    checkOutput("lock fault err4", 64'(err_of(4)), 64'd1);
    ticks(1039);
    checkOutput("lock pre-timeout state4", 64'(st_of(4)), 64'd2);
    checkOutput("lock pre-timeout retry4", 64'(retry_of(4)), 64'd0);
    tick();
    checkOutput("lock timeout state4", 64'(st_of(4)), 64'd1);
    checkOutput("lock timeout retry4", 64'(retry_of(4)), 64'd1);
    ticks(1040 * 16);
    checkOutput("retry4 saturated", 64'(retry_of(4)), 64'd15);
    checkOutput("retry4 sat state4", 64'(st_of(4)), 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/xaui_link_sequencer.md
XAUI_LINK_SEQUENCER -- requirements
Module: xaui_link_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 8, meaning the number of XAUI channels (legal range 1..8).
REQ-002 SHALL have parameter ENABLE, default 8'h30, meaning an N_CH-bit channel enable mask; bit i enables channel i.
REQ-003 SHALL have parameter RST_CYCLES, default 16, meaning the rx reset pulse length in cycles (legal range 1..255).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1024, meaning the WAIT_LOCK timeout in cycles.
REQ-005 SHALL have parameter SYNC_TIMEOUT, default 4096, meaning the ALIGN timeout in cycles.
REQ-006 SHALL have parameter BOND_CYCLES, default 64, meaning the clean cycles required in BOND before UP.
REQ-007 SHALL have parameter CNT_W, default 8, meaning the width of the error counter and the retry counter.
REQ-008 SHALL have port: xaui_clk  in  1  sole clock; all logic on its rising edge.
REQ-009 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-010 SHALL have port: resync  in  N_CH  per-channel single-cycle request to restart link bring-up.
REQ-011 SHALL have port: mgt_rxlock  in  4*N_CH  per-lane CDR lock; channel i uses bits [4i+3:4i].
REQ-012 SHALL have port: mgt_rxsyncok  in  4*N_CH  per-lane comma-alignment achieved.
REQ-013 SHALL have port: mgt_rxbufferr  in  4*N_CH  per-lane elastic buffer error.
REQ-014 SHALL have port: mgt_rx_rst  out  N_CH  per-channel rx reset to the transceivers.
REQ-015 SHALL have port: mgt_rxencommaalign  out  4*N_CH  per-lane comma-align enable.
REQ-016 SHALL have port: mgt_rxenchansync  out  N_CH  per-channel channel-bonding enable.
REQ-017 SHALL have port: link_up  out  N_CH  per-channel link operational.
REQ-018 SHALL have port: link_state  out  3*N_CH  per-channel state code.
REQ-019 SHALL have port: err_count  out  CNT_W*N_CH  per-channel count of faults that dropped the link from UP.
REQ-020 SHALL have port: retry_count  out  CNT_W*N_CH  per-channel count of timeouts.

Function
REQ-021 SHALL implement an independent FSM per channel with state codes DISABLED=0, RESET=1, WAIT_LOCK=2, ALIGN=3, BOND=4, UP=5.
REQ-022 SHALL keep every channel whose ENABLE bit is 0 in DISABLED permanently, with all of its outputs held at 0 and all inputs ignored.
REQ-023 SHALL, in RESET, drive mgt_rx_rst high for exactly RST_CYCLES cycles and then enter WAIT_LOCK.
REQ-024 SHALL, in WAIT_LOCK, enter ALIGN once all 4 lane rxlock bits are high; on reaching LOCK_TIMEOUT cycles without that, it SHALL enter RESET and increment retry_count.
REQ-025 SHALL, in ALIGN, drive the 4 lane mgt_rxencommaalign bits to 4'hF and enter BOND once all 4 rxsyncok bits are high; on reaching SYNC_TIMEOUT cycles without that, it SHALL enter RESET and increment retry_count.
REQ-026 SHALL, in BOND, drive mgt_rxenchansync high and enter UP after BOND_CYCLES consecutive cycles with all rxlock and rxsyncok high and all rxbufferr low; any violating cycle SHALL restart the BOND count from 0.
REQ-027 SHALL, in UP, hold link_up=1, mgt_rxenchansync=1 and mgt_rxencommaalign=0.
REQ-028 SHALL treat any rxlock low, any rxsyncok low or any rxbufferr high while in UP as a fault: enter RESET and increment err_count.
REQ-029 SHALL, when resync is high in any state other than DISABLED, enter RESET on the next cycle without incrementing either counter.
REQ-030 SHALL, when resync and a fault occur in the same UP cycle, enter RESET and increment err_count exactly once.
REQ-031 SHALL clear the per-channel cycle timer on every state entry, including re-entry into RESET from RESET.
REQ-032 SHALL saturate err_count and retry_count at 2^CNT_W-1; they SHALL never wrap.
REQ-033 SHALL produce all outputs from registers or from decode of registered state, with no combinational path from any input to any output.
REQ-034 SHALL make a state transition take effect in the cycle after its condition is sampled.

Reset
REQ-035 SHALL, while reset is high, put enabled channels in RESET with the timer at 0, and disabled channels in DISABLED.
REQ-036 SHALL, while reset is high, drive mgt_rx_rst to ENABLE and all other outputs to 0, and clear both counters.
REQ-037 SHALL, if reset is asserted mid-operation (any state), take it as above on the next edge, discarding any partial count.

Verification
REQ-038 SHALL cover nominal bring-up: ENABLE=8'h30, reset released, all rxlock/rxsyncok high, rxbufferr 0 -> ch4/ch5 rx_rst high for 16 cycles and link_up=1 after 16+1+1+64 cycles; ch0-3 and ch6-7 outputs stay 0.
REQ-039 SHALL cover lock timeout: ch4 rxlock held at 0 -> RESET re-entered every 16+1024 cycles, with retry_count4 incrementing and saturating at 255.
REQ-040 SHALL cover a UP fault: rxbufferr lane 2 of ch5 pulsed for 1 cycle -> link_up5 falls next cycle, err_count5=1, and bring-up repeats.
REQ-041 SHALL cover a BOND glitch: rxsyncok dropped for 1 cycle at BOND count 60 -> UP reached 64 clean cycles after the glitch, not before.
REQ-042 SHALL cover simultaneous resync and fault in UP -> err_count increments by 1 only; resync alone -> both counters unchanged.
REQ-043 SHALL cover reset pulsed mid-ALIGN -> state=RESET, counters=0, and mgt_rxencommaalign=0 on the next cycle.
